dc_ipu_filter_mode_ctrl: RTL and testbench

DC_IPU_FILTER_MODE_CTRL -- requirements
Module: dc_ipu_filter_mode_ctrl

---
 rtl/dc_ipu_filter_mode_ctrl.sv | 137 +++++++++++++
 tb/tb_dc_ipu_filter_mode_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dc_ipu_filter_mode_ctrl.sv
// dc_ipu_filter_mode_ctrl
//   Controls which scale method the texture filter uses. A method change is
//   never applied while transfers are still in flight. On a request the block
//   stops accepting new texel quads (DRAIN) and waits for the filter to retire
//   every outstanding transfer. It then applies the new method (APPLY) and
//   resumes (RUN).
//
// Ports
//   clk, nreset      clock; synchronous active-low reset
//   clr              synchronous clear (scale_method is kept)
//   cfg_method       requested method (00 nearest, 01 linear, 10 cubic, 11 magic)
//   cfg_update       one-cycle request to apply cfg_method
//   cfg_busy         high while a change is pending (DRAIN/APPLY)
//   cfg_done         one-cycle pulse when the new method takes effect
//   up_valid/up_ready           upstream handshake
//   flt_in_valid/flt_in_ready   filter input handshake
//   flt_out_valid/flt_out_ready filter output handshake (monitored only)
//   scale_method     registered method driven to the filter
//   inflight         transfers accepted but not yet retired
//   err              sticky counter-underflow flag
module dc_ipu_filter_mode_ctrl #(
  parameter int unsigned CNT_WIDTH = 5
) (
  input  logic                 clk,
  input  logic                 nreset,
  input  logic                 clr,
  input  logic [1:0]           cfg_method,
  input  logic                 cfg_update,
  output logic                 cfg_busy,
  output logic                 cfg_done,
  input  logic                 up_valid,
  output logic                 up_ready,
  output logic                 flt_in_valid,
  input  logic                 flt_in_ready,
  input  logic                 flt_out_valid,
  input  logic                 flt_out_ready,
  output logic [1:0]           scale_method,
  output logic [CNT_WIDTH-1:0] inflight,
  output logic                 err
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    APPLY = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  state_t               state, state_nxt;
  logic [1:0]           pending_method, pending_nxt;
  logic [1:0]           method_nxt;
  logic [CNT_WIDTH-1:0] inflight_nxt;
  logic                 err_nxt;
  logic                 done_nxt;
  logic                 run, not_full, accept, retire;

  always_comb begin
    run          = (state == RUN);
    not_full     = (inflight != CNT_MAX);
    flt_in_valid = up_valid & run & not_full;
    up_ready     = flt_in_ready & run & not_full;
    accept       = flt_in_valid & flt_in_ready;
    retire       = flt_out_valid & flt_out_ready;
    cfg_busy     = !run;

    // A simultaneous accept and retire cancel out, so the underflow case is
    // only a retire with nothing outstanding and no accept alongside it.
    inflight_nxt = inflight;
    err_nxt      = err;
    if (accept && !retire) begin
      inflight_nxt = inflight + CNT_ONE;
    end else if (retire && !accept) begin
      if (inflight == '0) begin
        err_nxt = 1'b1;
      end else begin
        inflight_nxt = inflight - CNT_ONE;
      end
    end

    state_nxt   = state;
    pending_nxt = pending_method;
    method_nxt  = scale_method;
    done_nxt    = 1'b0;
    unique case (state)
      RUN: begin
        if (cfg_update) begin
          pending_nxt = cfg_method;
          state_nxt   = DRAIN;
        end
      end
      DRAIN: begin
        if (cfg_update) begin
          pending_nxt = cfg_method;
        end
        // Empty at the start of the cycle and nothing retiring now.
        if ((inflight == '0) && !retire) begin
          state_nxt = APPLY;
        end
      end
      APPLY: begin
        method_nxt = pending_method;
        done_nxt   = 1'b1;
        state_nxt  = RUN;
      end
      default: begin
        state_nxt = RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state          <= RUN;
      scale_method   <= '0;
      pending_method <= '0;
      inflight       <= '0;
      cfg_done       <= 1'b0;
      err            <= 1'b0;
    end else if (clr) begin
      state          <= RUN;
      pending_method <= '0;
      inflight       <= '0;
      cfg_done       <= 1'b0;
      err            <= 1'b0;
    end else begin
      state          <= state_nxt;
      scale_method   <= method_nxt;
      pending_method <= pending_nxt;
      inflight       <= inflight_nxt;
      cfg_done       <= done_nxt;
      err            <= err_nxt;
    end
  end

endmodule

// File: tb/tb_dc_ipu_filter_mode_ctrl.sv
// Self-checking bench for dc_ipu_filter_mode_ctrl, built with CNT_WIDTH=2 so
// the full-pipeline limit (3 in flight) is reached quickly.
module tb_dc_ipu_filter_mode_ctrl;

  localparam int unsigned CW   = 2;
  localparam int          MAXV = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          nreset = 1'b0;
  logic          clr = 1'b0;
  logic [1:0]    cfg_method = 2'b00;
  logic          cfg_update = 1'b0;
  logic          cfg_busy;
  logic          cfg_done;
  logic          up_valid = 1'b0;
  logic          up_ready;
  logic          flt_in_valid;
  logic          flt_in_ready = 1'b0;
  logic          flt_out_valid = 1'b0;
  logic          flt_out_ready = 1'b0;
  logic [1:0]    scale_method;
  logic [CW-1:0] inflight;
  logic          err;

  int n_cmp = 0;
  int n_bad = 0;

  dc_ipu_filter_mode_ctrl #(.CNT_WIDTH(CW)) dut (
    .clk(clk), .nreset(nreset), .clr(clr),
    .cfg_method(cfg_method), .cfg_update(cfg_update),
    .cfg_busy(cfg_busy), .cfg_done(cfg_done),
    .up_valid(up_valid), .up_ready(up_ready),
    .flt_in_valid(flt_in_valid), .flt_in_ready(flt_in_ready),
    .flt_out_valid(flt_out_valid), .flt_out_ready(flt_out_ready),
    .scale_method(scale_method), .inflight(inflight), .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    clr = 1'b0; cfg_update = 1'b0; up_valid = 1'b0;
    flt_in_ready = 1'b0; flt_out_valid = 1'b0; flt_out_ready = 1'b0;
  endtask

  task automatic test_reset();
    nreset = 1'b0; clr = 1'b1; cfg_update = 1'b1; cfg_method = 2'b11;
    up_valid = 1'b1; flt_in_ready = 1'b1; flt_out_valid = 1'b1; flt_out_ready = 1'b1;
    tick(); tick();
    nreset = 1'b1; idle_inputs(); flt_in_ready = 1'b1; #1;
    n_cmp++; if (scale_method !== 2'b00) begin n_bad++; $display("FAIL reset_scale: got %b want 00", scale_method); end
    n_cmp++; if (inflight !== 2'd0) begin n_bad++; $display("FAIL reset_inflight: got %0d want 0", inflight); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", err); end
    n_cmp++; if (cfg_done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", cfg_done); end
    n_cmp++; if (cfg_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", cfg_busy); end
    n_cmp++; if (up_ready !== 1'b1) begin n_bad++; $display("FAIL reset_up_ready: got %b want 1", up_ready); end
  endtask

  // Empty pipeline: update at t -> DRAIN t+1, APPLY t+2, new method at t+3.
  task automatic test_idle_latency();
    cfg_method = 2'b10; cfg_update = 1'b1; flt_in_ready = 1'b1; #1;
    n_cmp++; if (up_ready !== 1'b1) begin n_bad++; $display("FAIL lat_ready_t0: got %b want 1", up_ready); end
    tick(); cfg_update = 1'b0; #1;
    n_cmp++; if (up_ready !== 1'b0) begin n_bad++; $display("FAIL lat_ready_t1: got %b want 0", up_ready); end
    n_cmp++; if (cfg_busy !== 1'b1) begin n_bad++; $display("FAIL lat_busy_t1: got %b want 1", cfg_busy); end
    tick();
    n_cmp++; if (up_ready !== 1'b0) begin n_bad++; $display("FAIL lat_ready_t2: got %b want 0", up_ready); end
    n_cmp++; if (cfg_done !== 1'b0 || scale_method !== 2'b00) begin n_bad++; $display("FAIL lat_t2: got done=%b scale=%b want 0/00", cfg_done, scale_method); end
    tick();
    n_cmp++; if (scale_method !== 2'b10) begin n_bad++; $display("FAIL lat_scale_t3: got %b want 10", scale_method); end
    n_cmp++; if (cfg_done !== 1'b1) begin n_bad++; $display("FAIL lat_done_t3: got %b want 1", cfg_done); end
    n_cmp++; if (cfg_busy !== 1'b0 || up_ready !== 1'b1) begin n_bad++; $display("FAIL lat_run_t3: got busy=%b ready=%b want 0/1", cfg_busy, up_ready); end
    tick();
    n_cmp++; if (cfg_done !== 1'b0) begin n_bad++; $display("FAIL lat_done_t4: got %b want 0", cfg_done); end
    idle_inputs();
  endtask

  // Three in flight, then a change to 01: drains, applies, resumes.
  task automatic test_drain_three();
    up_valid = 1'b1; flt_in_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if (up_ready !== 1'b1) begin n_bad++; $display("FAIL drain_accept%0d: got %b want 1", i, up_ready); end
      tick();
    end
    n_cmp++; if (inflight !== 2'd3 || up_ready !== 1'b0) begin n_bad++; $display("FAIL drain_full: got inflight=%0d ready=%b want 3/0", inflight, up_ready); end
    up_valid = 1'b0; cfg_method = 2'b01; cfg_update = 1'b1;
    tick(); cfg_update = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_cmp++; if (cfg_busy !== 1'b1 || inflight !== 2'd3 || cfg_done !== 1'b0) begin n_bad++; $display("FAIL drain_wait%0d: got busy=%b inflight=%0d done=%b want 1/3/0", i, cfg_busy, inflight, cfg_done); end
      tick();
    end
    flt_out_valid = 1'b1; flt_out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_cmp++; if (cfg_busy !== 1'b1) begin n_bad++; $display("FAIL drain_busy_ret%0d: got %b want 1", k, cfg_busy); end
      tick();
      n_cmp++; if (inflight !== 2'(2 - k)) begin n_bad++; $display("FAIL drain_cnt_ret%0d: got %0d want %0d", k, inflight, 2 - k); end
    end
    flt_out_valid = 1'b0; flt_out_ready = 1'b0; #1;
    n_cmp++; if (cfg_busy !== 1'b1 || scale_method !== 2'b10 || cfg_done !== 1'b0) begin n_bad++; $display("FAIL drain_last: got busy=%b scale=%b done=%b want 1/10/0", cfg_busy, scale_method, cfg_done); end
    tick();
    n_cmp++; if (cfg_busy !== 1'b1 || scale_method !== 2'b10 || cfg_done !== 1'b0 || up_ready !== 1'b0) begin n_bad++; $display("FAIL drain_apply: got busy=%b scale=%b done=%b ready=%b want 1/10/0/0", cfg_busy, scale_method, cfg_done, up_ready); end
    tick();
    n_cmp++; if (scale_method !== 2'b01 || cfg_done !== 1'b1 || cfg_busy !== 1'b0) begin n_bad++; $display("FAIL drain_done: got scale=%b done=%b busy=%b want 01/1/0", scale_method, cfg_done, cfg_busy); end
    tick();
    idle_inputs();
  endtask

  // 01 then 11 during DRAIN: one cfg_done, 11 wins; update in APPLY ignored.
  task automatic test_last_wins();
    int dones = 0;
    up_valid = 1'b1; flt_in_ready = 1'b1;
    tick(); up_valid = 1'b0;
    cfg_method = 2'b01; cfg_update = 1'b1; tick();
    cfg_method = 2'b11; tick();
    cfg_update = 1'b0; flt_out_valid = 1'b1; flt_out_ready = 1'b1;
    tick(); flt_out_valid = 1'b0; flt_out_ready = 1'b0;
    if (cfg_done === 1'b1) dones++;
    tick();
    if (cfg_done === 1'b1) dones++;
    cfg_method = 2'b00; cfg_update = 1'b1; #1;
    n_cmp++; if (cfg_busy !== 1'b1) begin n_bad++; $display("FAIL lw_apply_busy: got %b want 1", cfg_busy); end
    tick(); cfg_update = 1'b0;
    if (cfg_done === 1'b1) dones++;
    n_cmp++; if (scale_method !== 2'b11) begin n_bad++; $display("FAIL lw_scale: got %b want 11", scale_method); end
    for (int i = 0; i < 4; i++) begin
      tick();
      if (cfg_done === 1'b1) dones++;
      n_cmp++; if (cfg_busy !== 1'b0) begin n_bad++; $display("FAIL lw_apply_ignored%0d: got busy=%b want 0", i, cfg_busy); end
    end
    n_cmp++; if (dones != 1) begin n_bad++; $display("FAIL lw_done_count: got %0d want 1", dones); end
    n_cmp++; if (scale_method !== 2'b11) begin n_bad++; $display("FAIL lw_scale_end: got %b want 11", scale_method); end
    idle_inputs();
  endtask

  // Filter never retires: exactly MAXV accepts, then back-pressure.
  task automatic test_full();
    int acc = 0;
    up_valid = 1'b1; flt_in_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (up_ready === 1'b1 && flt_in_valid === 1'b1) acc++;
      tick();
    end
    n_cmp++; if (acc != MAXV) begin n_bad++; $display("FAIL full_accepts: got %0d want %0d", acc, MAXV); end
    n_cmp++; if (inflight !== 2'(MAXV) || up_ready !== 1'b0 || flt_in_valid !== 1'b0) begin n_bad++; $display("FAIL full_stall: got inflight=%0d ready=%b valid=%b want %0d/0/0", inflight, up_ready, flt_in_valid, MAXV); end
    flt_out_valid = 1'b1; flt_out_ready = 1'b1;
    tick(); flt_out_valid = 1'b0; #1;
    n_cmp++; if (inflight !== 2'd2 || up_ready !== 1'b1) begin n_bad++; $display("FAIL full_reopen: got inflight=%0d ready=%b want 2/1", inflight, up_ready); end
    flt_out_valid = 1'b1; tick();
    n_cmp++; if (inflight !== 2'd2) begin n_bad++; $display("FAIL full_acc_ret: got %0d want 2", inflight); end
    up_valid = 1'b0; tick(); tick();
    n_cmp++; if (inflight !== 2'd0 || err !== 1'b0) begin n_bad++; $display("FAIL full_drain: got inflight=%0d err=%b want 0/0", inflight, err); end
    idle_inputs();
  endtask

  task automatic test_err();
    flt_out_valid = 1'b1; flt_out_ready = 1'b1;
    tick(); flt_out_valid = 1'b0; flt_out_ready = 1'b0;
    n_cmp++; if (err !== 1'b1 || inflight !== 2'd0) begin n_bad++; $display("FAIL err_set: got err=%b inflight=%0d want 1/0", err, inflight); end
    tick(); tick(); tick();
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL err_sticky: got %b want 1", err); end
    clr = 1'b1; tick(); clr = 1'b0;
    n_cmp++; if (err !== 1'b0 || scale_method !== 2'b11 || cfg_done !== 1'b0) begin n_bad++; $display("FAIL err_clr: got err=%b scale=%b done=%b want 0/11/0", err, scale_method, cfg_done); end
    idle_inputs();
  endtask

  // clr during DRAIN aborts the pending 10 while scale_method stays 01.
  task automatic test_clr_drain();
    int dones = 0;
    cfg_method = 2'b01; cfg_update = 1'b1; tick(); cfg_update = 1'b0;
    tick(); tick(); tick();
    n_cmp++; if (scale_method !== 2'b01) begin n_bad++; $display("FAIL clr_setup: got %b want 01", scale_method); end
    up_valid = 1'b1; flt_in_ready = 1'b1; tick(); up_valid = 1'b0;
    cfg_method = 2'b10; cfg_update = 1'b1; tick(); cfg_update = 1'b0; #1;
    n_cmp++; if (cfg_busy !== 1'b1 || inflight !== 2'd1) begin n_bad++; $display("FAIL clr_in_drain: got busy=%b inflight=%0d want 1/1", cfg_busy, inflight); end
    clr = 1'b1; tick(); clr = 1'b0; #1;
    n_cmp++; if (cfg_busy !== 1'b0 || inflight !== 2'd0 || scale_method !== 2'b01 || cfg_done !== 1'b0 || up_ready !== 1'b1) begin n_bad++; $display("FAIL clr_abort: got busy=%b inflight=%0d scale=%b done=%b ready=%b want 0/0/01/0/1", cfg_busy, inflight, scale_method, cfg_done, up_ready); end
    for (int i = 0; i < 5; i++) begin
      tick();
      if (cfg_done === 1'b1) dones++;
    end
    n_cmp++; if (dones != 0 || scale_method !== 2'b01) begin n_bad++; $display("FAIL clr_no_done: got dones=%0d scale=%b want 0/01", dones, scale_method); end
    idle_inputs();
  endtask

  // Random traffic against a transaction-level reference: a count of
  // outstanding transfers, a sticky underflow flag, and a change request
  // that is held back until the count has stayed at zero for a cycle.
  task automatic test_random(input int n);
    int  cnt, pend, meth, phase;
    bit  e, done, acc, ret, upd_pending;
    bit  exp_rdy, exp_vld;
    nreset = 1'b0; idle_inputs(); tick(); nreset = 1'b1;
    cnt = 0; pend = 0; meth = 0; phase = 0; e = 1'b0; done = 1'b0;
    for (int c = 0; c < n; c++) begin
      nreset        = ($urandom_range(0, 149) != 0);
      clr           = ($urandom_range(0, 59) == 0);
      cfg_update    = ($urandom_range(0, 9) == 0);
      cfg_method    = 2'($urandom_range(0, 3));
      up_valid      = 1'($urandom_range(0, 1));
      flt_in_ready  = 1'($urandom_range(0, 1));
      flt_out_valid = 1'($urandom_range(0, 1));
      flt_out_ready = ($urandom_range(0, 3) != 0);
      #1;
      exp_rdy = flt_in_ready && phase == 0 && cnt < MAXV;
      exp_vld = up_valid && phase == 0 && cnt < MAXV;
      n_cmp++; if (up_ready !== exp_rdy) begin n_bad++; $display("FAIL rnd_up_ready c%0d: got %b want %b", c, up_ready, exp_rdy); end
      n_cmp++; if (flt_in_valid !== exp_vld) begin n_bad++; $display("FAIL rnd_flt_in_valid c%0d: got %b want %b", c, flt_in_valid, exp_vld); end
      n_cmp++; if (cfg_busy !== (phase != 0)) begin n_bad++; $display("FAIL rnd_busy c%0d: got %b want %b", c, cfg_busy, phase != 0); end
      n_cmp++; if (scale_method !== 2'(meth)) begin n_bad++; $display("FAIL rnd_scale c%0d: got %b want %0d", c, scale_method, meth); end
      n_cmp++; if (inflight !== CW'(cnt)) begin n_bad++; $display("FAIL rnd_inflight c%0d: got %0d want %0d", c, inflight, cnt); end
      n_cmp++; if (err !== e) begin n_bad++; $display("FAIL rnd_err c%0d: got %b want %b", c, err, e); end
      n_cmp++; if (cfg_done !== done) begin n_bad++; $display("FAIL rnd_done c%0d: got %b want %b", c, cfg_done, done); end
      acc = exp_vld && flt_in_ready;
      ret = flt_out_valid && flt_out_ready;
      if (!nreset) begin
        cnt = 0; pend = 0; meth = 0; phase = 0; e = 1'b0; done = 1'b0;
      end else if (clr) begin
        cnt = 0; pend = 0; phase = 0; e = 1'b0; done = 1'b0;
      end else begin
        done = 1'b0;
        upd_pending = (phase == 1) && cnt == 0 && !ret;
        if (phase == 2) begin
          meth = pend; done = 1'b1; phase = 0;
        end else if (cfg_update) begin
          pend = cfg_method; phase = 1;
        end
        if (upd_pending) phase = 2;
        if (acc && !ret) cnt++;
        else if (ret && !acc) begin
          if (cnt == 0) e = 1'b1;
          else cnt--;
        end
      end
      tick();
    end
    nreset = 1'b1; idle_inputs();
  endtask

  initial begin
    test_reset();
    test_idle_latency();
    test_drain_three();
    test_last_wins();
    test_full();
    test_err();
    test_clr_drain();
    test_random(800);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
